hilo_unit: RTL and testbench

//   EX-stage consumer of the ALU's multiply/divide outputs. Owns the architectural HI/LO registers.

---
 rtl/hilo_pkg.sv | 49 ++++
 rtl/hilo_unit.sv | 136 +++++++++++++
 tb/tb_hilo_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO register unit.
package hilo_pkg;

    localparam int unsigned HL_WIDTH = 32;
    localparam int unsigned HL_OP_W  = 3;

    // EX-stage HI/LO operation class
    typedef enum logic [HL_OP_W-1:0] {
        HL_NONE = 3'd0,
        HL_MD   = 3'd1,
        HL_MTHI = 3'd2,
        HL_MTLO = 3'd3,
        HL_MFHI = 3'd4,
        HL_MFLO = 3'd5
    } hl_op_t;

    // Pending-result tracker state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        CANCEL = 2'd2
    } hl_state_t;

    // HI/LO pair produced by a mul/div commit
    typedef struct packed {
        logic [HL_WIDTH-1:0] hi;
        logic [HL_WIDTH-1:0] lo;
    } hl_pair_t;

    // Map the ALU's 64-bit output onto HI/LO: mult = {hi,lo}, div = {quotient,remainder}
    function automatic hl_pair_t hl_split(input logic [2*HL_WIDTH-1:0] hilo, input logic is_div);
        hl_pair_t p;
        if (is_div) begin
            p.hi = hilo[HL_WIDTH-1:0];
            p.lo = hilo[2*HL_WIDTH-1:HL_WIDTH];
        end else begin
            p.hi = hilo[2*HL_WIDTH-1:HL_WIDTH];
            p.lo = hilo[HL_WIDTH-1:0];
        end
        return p;
    endfunction

    // True for every op that reads or writes HI/LO or launches a mul/div
    function automatic logic hl_uses_hilo(input hl_op_t op);
        return (op == HL_MD) || (op == HL_MTHI) || (op == HL_MTLO) ||
               (op == HL_MFHI) || (op == HL_MFLO);
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with mul/div result tracking, MT*/MF* execution and hazard stalls.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH  = HL_WIDTH,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [2:0]         hl_op,
    input  logic               md_is_div,
    input  logic               md_start,
    input  logic               md_done,
    input  logic [2*WIDTH-1:0] md_hilo,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               flush,
    output logic [WIDTH-1:0]   rdata,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               stall_req,
    output logic               busy
);

    hl_state_t        state_q, state_d;
    logic             pend_div_q, pend_div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    hl_op_t   op;
    logic     uses_hilo;
    logic     is_mf;
    logic     act;
    logic     fwd;
    hl_pair_t commit;

    // Decode the EX op and form the value a done cycle would commit
    always_comb begin
        op        = hl_op_t'(hl_op);
        uses_hilo = ex_valid & hl_uses_hilo(op);
        is_mf     = (op == HL_MFHI) || (op == HL_MFLO);
        commit    = hl_split(md_hilo, pend_div_q);
        fwd       = FWD_EN && (state_q == BUSY) && md_done && !flush;
    end

    // Stall any HI/LO user while a result is outstanding; forwarded MF* in the done cycle may proceed
    always_comb begin
        stall_req = 1'b0;
        case (state_q)
            IDLE:    stall_req = 1'b0;
            BUSY:    stall_req = uses_hilo & ~(FWD_EN & md_done & is_mf);
            CANCEL:  stall_req = uses_hilo;
            default: stall_req = 1'b0;
        endcase
    end

    // An instruction only takes effect when valid, not flushed and not held
    always_comb begin
        act = ex_valid & ~flush & ~stall_req;
    end

    // Next-state, launch tracking, commit and MT* writes
    always_comb begin
        state_d    = state_q;
        pend_div_d = pend_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (act && (op == HL_MD) && md_start) begin
                    state_d    = BUSY;
                    pend_div_d = md_is_div;
                end
                if (act && (op == HL_MTHI)) begin
                    hi_d = wdata;
                end
                if (act && (op == HL_MTLO)) begin
                    lo_d = wdata;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d = IDLE;
                    if (!flush) begin
                        hi_d = commit.hi;
                        lo_d = commit.lo;
                    end
                end else if (flush) begin
                    state_d = CANCEL;
                end
            end
            CANCEL: begin
                // The orphan result is dropped when it finally arrives
                if (md_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MF* read path, bypassing the committing value when forwarding applies
    always_comb begin
        rdata = '0;
        case (op)
            HL_MFHI: rdata = fwd ? commit.hi : hi_q;
            HL_MFLO: rdata = fwd ? commit.lo : lo_q;
            default: rdata = '0;
        endcase
    end

    // State and HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pend_div_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            pend_div_q <= pend_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Debug/trace views of the architectural state
    always_comb begin
        hi   = hi_q;
        lo   = lo_q;
        busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the bench plays the ALU and EX stage, predicts each cycle from the rules.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  hl_op;
    logic        md_is_div;
    logic        md_start;
    logic        md_done;
    logic [63:0] md_hilo;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;
    logic        busy;

    hilo_unit #(.WIDTH(32), .FWD_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .hl_op     (hl_op),
        .md_is_div (md_is_div),
        .md_start  (md_start),
        .md_done   (md_done),
        .md_hilo   (md_hilo),
        .wdata     (wdata),
        .flush     (flush),
        .rdata     (rdata),
        .hi        (hi),
        .lo        (lo),
        .stall_req (stall_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        stall;
        logic [31:0] rdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    bit   stim_done = 1'b0;

    // Reference model: architectural HI/LO plus what kind of result is still owed
    logic [31:0] m_hi, m_lo;
    int          m_pend;   // 0 nothing owed, 1 live result, 2 result to be discarded
    logic        m_div;
    int          alu_cnt;

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, id, got, exp);
        end
    endtask

    task automatic set_idle_inputs();
        ex_valid  = 1'b0;
        hl_op     = 3'(HL_NONE);
        md_is_div = 1'b0;
        md_start  = 1'b0;
        md_done   = 1'b0;
        md_hilo   = 64'h0;
        wdata     = 32'h0;
        flush     = 1'b0;
    endtask

    task automatic model_clear();
        m_hi   = 32'h0;
        m_lo   = 32'h0;
        m_pend = 0;
        m_div  = 1'b0;
    endtask

    // Drive one EX cycle, predict its outcome, queue the prediction, advance the model
    task automatic cyc(input logic v, input hl_op_t op, input logic div, input logic st,
                       input logic dn, input logic [63:0] hl, input logic [31:0] wd, input logic fl);
        exp_t        e;
        logic        uses, ismf, stl, act, fwdc;
        logic [31:0] c_hi, c_lo;
        @(negedge clk);
        ex_valid  = v;
        hl_op     = 3'(op);
        md_is_div = div;
        md_start  = st;
        md_done   = dn;
        md_hilo   = hl;
        wdata     = wd;
        flush     = fl;

        uses = v && (op != HL_NONE);
        ismf = (op == HL_MFHI) || (op == HL_MFLO);
        if (m_pend == 0)                   stl = 1'b0;
        else if (m_pend == 1 && dn && ismf) stl = 1'b0;
        else                                stl = uses;
        act  = v && !fl && !stl;

        if (m_div) begin
            c_hi = hl[31:0];
            c_lo = hl[63:32];
        end else begin
            c_hi = hl[63:32];
            c_lo = hl[31:0];
        end
        fwdc = (m_pend == 1) && dn && !fl;

        e.id    = cyc_no;
        e.stall = stl;
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.busy  = (m_pend != 0);
        e.rdata = 32'h0;
        if (op == HL_MFHI) e.rdata = fwdc ? c_hi : m_hi;
        if (op == HL_MFLO) e.rdata = fwdc ? c_lo : m_lo;
        sb_q.push_back(e);

        if (m_pend == 0) begin
            if (act && op == HL_MD && st) begin
                m_pend = 1;
                m_div  = div;
            end
            if (act && op == HL_MTHI) m_hi = wd;
            if (act && op == HL_MTLO) m_lo = wd;
        end else if (m_pend == 1) begin
            if (dn) begin
                if (!fl) begin
                    m_hi = c_hi;
                    m_lo = c_lo;
                end
                m_pend = 0;
            end else if (fl) begin
                m_pend = 2;
            end
        end else begin
            if (dn) m_pend = 0;
        end
        cyc_no++;
    endtask

    task automatic idle();
        cyc(1'b0, HL_NONE, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_idle_inputs();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compare every presented cycle against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall_req", e.id, {31'h0, stall_req}, {31'h0, e.stall});
                chk("rdata",     e.id, rdata, e.rdata);
                chk("hi",        e.id, hi,    e.hi);
                chk("lo",        e.id, lo,    e.lo);
                chk("busy",      e.id, {31'h0, busy}, {31'h0, e.busy});
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic        v, fl, div, st, dn;
        hl_op_t      op;
        logic [31:0] wd;
        logic [63:0] hl;
        int          wait_cnt;

        rst = 1'b0;
        set_idle_inputs();
        model_clear();
        alu_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // MULT with a 3-cycle latency
        cyc(1'b1, HL_MD, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        idle();
        idle();
        cyc(1'b0, HL_NONE, 1'b0, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFLO, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // DIV with MFLO forwarded in the done cycle
        cyc(1'b1, HL_MD, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        idle();
        cyc(1'b1, HL_MFLO, 1'b0, 1'b0, 1'b1, {32'd7, 32'd2}, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // MFHI held during BUSY, released with the committing value
        cyc(1'b1, HL_MD, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFLO, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // MTHI in the done cycle stalls once, then overrides the multiply's HI
        cyc(1'b1, HL_MD, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        idle();
        cyc(1'b1, HL_MTHI, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 32'h0000_A5A5, 1'b0);
        cyc(1'b1, HL_MTHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_A5A5, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFLO, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // Flush in BUSY cycle 1: orphan result discarded, MD/MF* held meanwhile
        cyc(1'b1, HL_MD, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b0, HL_NONE, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
        cyc(1'b1, HL_MD, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b1, HL_MD, 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_1111_2222, 32'h0, 1'b0);
        cyc(1'b1, HL_MFHI, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        idle();

        // Zero result is a legal commit
        cyc(1'b1, HL_MD, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        cyc(1'b0, HL_NONE, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0, 1'b0);
        idle();

        // md_done while IDLE is ignored
        cyc(1'b1, HL_MTLO, 1'b0, 1'b0, 1'b1, 64'h7777_8888_9999_AAAA, 32'h0BAD_CAFE, 1'b0);
        idle();

        // Reset mid-BUSY, then the late result arrives
        cyc(1'b1, HL_MD, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
        idle();
        do_reset();
        cyc(1'b0, HL_NONE, 1'b0, 1'b0, 1'b1, 64'h5555_6666_7777_8888, 32'h0, 1'b0);
        cyc(1'b1, HL_MFLO, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // Randomized traffic with a bench-side ALU of random latency
        alu_cnt = 0;
        repeat (3000) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = hl_op_t'(3'($urandom_range(0, 5)));
            fl  = ($urandom_range(0, 11) == 0);
            div = 1'($urandom_range(0, 1));
            wd  = $urandom;
            hl  = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            dn  = (alu_cnt == 1);
            st  = (op == HL_MD) && v && !fl && (m_pend == 0) && (alu_cnt == 0);
            cyc(v, op, div, st, dn, hl, wd, fl);
            if (alu_cnt > 0) alu_cnt--;
            if (st) alu_cnt = $urandom_range(1, 5);
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        idle();

        // Let the monitor drain, bounded
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued predictions expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
